// File: rtl/asyn_fifo_pkg.sv
// Shared definitions for the async FIFO: Gray/binary conversion and
// synchroniser depth limits used by both domain controllers.
package asyn_fifo_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 6;
    localparam int unsigned DEF_PTR_W       = DEF_ADDR_WIDTH + 1;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Widest pointer the helpers handle. Callers zero-extend into this width
    // and size-cast the result back to their own pointer width.
    localparam int unsigned PTR_MAX_W = 32;
    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down. Leading zeros from zero-extension do not
    // affect the lower bits, so the result is width generic.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = g;
        for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_sync_n.sv
// N-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Pure flop chain; no logic between stages.
module gray_ptr_sync_n #(
    parameter int unsigned WIDTH  = 7,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/asyn_fifo_rd_ctrl.sv
// Read-domain control of the async FIFO: read pointer, RAM read address and
// registered empty / almost_empty / level / sticky underflow status.
module asyn_fifo_rd_ctrl
    import asyn_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 4
) (
    input  logic                  read_clk,
    input  logic                  read_rst_n,
    input  logic [ADDR_WIDTH:0]   write_ptr,
    input  logic                  read_en,
    input  logic                  underflow_clr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH:0]   read_ptr_gray,
    output logic [ADDR_WIDTH:0]   sync_write_ptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   read_level,
    output logic                  underflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AE_LIMIT = PTR_W'(AE_THRESH);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
            $error("asyn_fifo_rd_ctrl: SYNC_STAGES out of range 2..4");
        end
        if (AE_THRESH >= (1 << ADDR_WIDTH)) begin : g_bad_thresh
            $error("asyn_fifo_rd_ctrl: AE_THRESH must be below the FIFO depth");
        end
    endgenerate

    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] rd_bin_next;
    logic [PTR_W-1:0] rd_gray_next;
    logic [PTR_W-1:0] level_next;
    logic             rd_fire;

    gray_ptr_sync_n #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (read_clk),
        .rst_n (read_rst_n),
        .d     (write_ptr),
        .q     (sync_write_ptr)
    );

    // Modulo-2**PTR_W arithmetic keeps level correct across pointer wrap;
    // MSB-different / rest-equal decodes to a full level, not empty.
    always_comb begin
        wbin         = PTR_W'(gray2bin(ptr_max_t'(sync_write_ptr)));
        rd_fire      = read_en & ~empty;
        rd_bin_next  = rd_bin + PTR_W'(rd_fire);
        rd_gray_next = PTR_W'(bin2gray(ptr_max_t'(rd_bin_next)));
        level_next   = wbin - rd_bin_next;
    end

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            rd_bin        <= '0;
            read_ptr_gray <= '0;
            empty         <= 1'b1;
            almost_empty  <= 1'b1;
            read_level    <= '0;
            underflow     <= 1'b0;
        end else begin
            rd_bin        <= rd_bin_next;
            read_ptr_gray <= rd_gray_next;
            empty         <= (rd_gray_next == sync_write_ptr);
            almost_empty  <= (level_next <= AE_LIMIT);
            read_level    <= level_next;
            // Set has priority over a simultaneous clear.
            if (read_en && empty) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    assign read_addr = rd_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_asyn_fifo_rd_ctrl.sv
// Directed bench for asyn_fifo_rd_ctrl with default parameters
// (ADDR_WIDTH 6, SYNC_STAGES 2, AE_THRESH 4).
module tb_asyn_fifo_rd_ctrl;

    logic       read_clk = 1'b0;
    logic       read_rst_n;
    logic [6:0] write_ptr;
    logic       read_en;
    logic       underflow_clr;
    logic [5:0] read_addr;
    logic [6:0] read_ptr_gray;
    logic [6:0] sync_write_ptr;
    logic       empty;
    logic       almost_empty;
    logic [6:0] read_level;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    asyn_fifo_rd_ctrl #(
        .ADDR_WIDTH  (6),
        .SYNC_STAGES (2),
        .AE_THRESH   (4)
    ) dut (
        .read_clk       (read_clk),
        .read_rst_n     (read_rst_n),
        .write_ptr      (write_ptr),
        .read_en        (read_en),
        .underflow_clr  (underflow_clr),
        .read_addr      (read_addr),
        .read_ptr_gray  (read_ptr_gray),
        .sync_write_ptr (sync_write_ptr),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .read_level     (read_level),
        .underflow      (underflow)
    );

    always #5 read_clk = ~read_clk;

    function automatic logic [6:0] g7(input int unsigned b);
        logic [6:0] v;
        v = b[6:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge read_clk);
    endtask

    task automatic check_status(input string tag, input logic e, input logic ae, input int unsigned lvl);
        check_eq({tag, ".empty"}, 32'(empty), 32'(e));
        check_eq({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        check_eq({tag, ".level"}, 32'(read_level), lvl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        logic [6:0]  prev_gray;
        logic        saw_wrap;

        read_rst_n    = 1'b0;
        write_ptr     = 7'h15;
        read_en       = 1'b1;
        underflow_clr = 1'b0;

        // Reset holds everything, read_en ignored
        tick(2);
        check_status("rst", 1'b1, 1'b1, 0);
        check_eq("rst.addr", 32'(read_addr), 0);
        check_eq("rst.underflow", 32'(underflow), 0);
        check_eq("rst.gray", 32'(read_ptr_gray), 0);
        check_eq("rst.sync", 32'(sync_write_ptr), 0);

        // Release: 7'h15 Gray = 25 binary, visible on the 3rd edge
        read_en    = 1'b0;
        read_rst_n = 1'b1;
        tick(2);
        check_eq("rel2.empty", 32'(empty), 1);
        check_eq("rel2.sync", 32'(sync_write_ptr), 32'h15);
        tick(1);
        check_status("rel3", 1'b0, 1'b0, 25);

        read_rst_n = 1'b0;
        write_ptr  = 7'h00;
        tick(1);
        read_rst_n = 1'b1;
        tick(3);
        check_eq("rst2.empty", 32'(empty), 1);

        // Single-step fill
        write_ptr = g7(1);
        tick(2);
        check_eq("fill2.empty", 32'(empty), 1);
        tick(1);
        check_status("fill3", 1'b0, 1'b1, 1);

        // Drain ten entries
        write_ptr = g7(10);
        tick(3);
        check_status("drain.pre", 1'b0, 1'b0, 10);
        read_en = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            check_eq("drain.addr", 32'(read_addr), i);
            check_eq("drain.level", 32'(read_level), 10 - i);
            check_eq("drain.ae", 32'(almost_empty), 32'((10 - i) <= 4));
            check_eq("drain.empty", 32'(empty), 0);
            tick(1);
        end
        read_en = 1'b0;
        check_status("drain.end", 1'b1, 1'b1, 0);
        check_eq("drain.addr_end", 32'(read_addr), 10);
        check_eq("drain.gray", 32'(read_ptr_gray), 32'(g7(10)));
        check_eq("drain.underflow", 32'(underflow), 0);

        // Underflow: set, set-wins-over-clear, then clear
        read_en = 1'b1;
        tick(1);
        check_eq("uf.set", 32'(underflow), 1);
        check_eq("uf.addr", 32'(read_addr), 10);
        underflow_clr = 1'b1;
        tick(1);
        check_eq("uf.setwins", 32'(underflow), 1);
        check_eq("uf.addr2", 32'(read_addr), 10);
        read_en = 1'b0;
        tick(1);
        check_eq("uf.clr", 32'(underflow), 0);
        underflow_clr = 1'b0;

        // Streaming wrap: one write and one read per cycle, steady level 1
        w         = 10;
        read_en   = 1'b1;
        saw_wrap  = 1'b0;
        prev_gray = read_ptr_gray;
        for (int unsigned i = 0; i < 200; i++) begin
            w         = (w + 1) % 128;
            write_ptr = g7(w);
            tick(1);
            if (prev_gray == g7(127) && read_ptr_gray == g7(0)) saw_wrap = 1'b1;
            prev_gray = read_ptr_gray;
            if (i >= 2) begin
                check_eq("wrap.empty", 32'(empty), 0);
                check_eq("wrap.level", 32'(read_level), 1);
            end
        end
        tick(5);
        check_status("wrap.end", 1'b1, 1'b1, 0);
        check_eq("wrap.addr", 32'(read_addr), 18);
        check_eq("wrap.gray", 32'(read_ptr_gray), 32'(g7(82)));
        check_eq("wrap.seen", 32'(saw_wrap), 1);
        read_en = 1'b0;

        // Full: MSB differs, rest equal
        read_rst_n = 1'b0;
        write_ptr  = 7'h00;
        tick(1);
        read_rst_n = 1'b1;
        write_ptr  = g7(64);
        tick(3);
        check_status("full", 1'b0, 1'b0, 64);

        // Asynchronous reset mid-drain
        read_en = 1'b1;
        tick(3);
        check_eq("mid.addr", 32'(read_addr), 3);
        check_eq("mid.level", 32'(read_level), 61);
        #2;
        read_rst_n = 1'b0;
        #1;
        check_status("mid.rst", 1'b1, 1'b1, 0);
        check_eq("mid.rst_addr", 32'(read_addr), 0);
        check_eq("mid.rst_gray", 32'(read_ptr_gray), 0);
        check_eq("mid.rst_sync", 32'(sync_write_ptr), 0);
        @(negedge read_clk);
        read_rst_n = 1'b1;
        tick(1);
        check_eq("mid.post_empty", 32'(empty), 1);
        check_eq("mid.post_addr", 32'(read_addr), 0);
        check_eq("mid.post_uf", 32'(underflow), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
